vc_io: RTL and testbench

- Memory-mapped I/O unit on the core's data port, selected when the core flags an I/O access.
- Provides the per-access read data and read/write done handshake for I/O, plus the core interrupt line.
- Contains a buffered 8N1 UART transmitter and a 16-bit compare timer.
- Register offsets 0x00-0x0F belong to the QSPI controller and are ignored here; this block decodes addr[7:4] = 1..7.

---
 rtl/vc_io_pkg.sv | 32 +++
 rtl/vc_uart_tx.sv | 149 ++++++++++++++
 rtl/vc_io.sv | 193 +++++++++++++++++++
 tb/tb_vc_io.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_io_pkg.sv
// Shared definitions for the vc_io memory-mapped I/O unit: register
// selects (addr[7:4]), control/status bit positions and the UART TX states.
package vc_io_pkg;

    localparam logic [3:0] REG_TXDATA  = 4'd1;
    localparam logic [3:0] REG_STATUS  = 4'd2;
    localparam logic [3:0] REG_DIVISOR = 4'd3;
    localparam logic [3:0] REG_COUNT   = 4'd4;
    localparam logic [3:0] REG_COMPARE = 4'd5;
    localparam logic [3:0] REG_CTRL    = 4'd6;
    localparam logic [3:0] REG_IRQ     = 4'd7;

    localparam int CTRL_TIMER_EN       = 0;
    localparam int CTRL_TIMER_IRQ_EN   = 1;
    localparam int CTRL_TXEMPTY_IRQ_EN = 2;

    localparam int IRQ_TIMER_PENDING   = 0;
    localparam int IRQ_TX_IDLE         = 1;

    localparam int STATUS_BUSY         = 0;
    localparam int STATUS_FULL         = 1;
    localparam int STATUS_EMPTY        = 2;
    localparam int STATUS_COUNT_LSB    = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/vc_uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a bit-serial
// shifter. Every bit (start, 8 data LSB first, stop) lasts divisor+1 clocks.
// The FIFO pops when the shifter enters START; a push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module vc_uart_tx
    import vc_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 12
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    data,
    input  logic [DIV_W-1:0]              divisor,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    tx_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    logic             bit_end;
    logic             pop;
    logic             push_ok;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign busy  = (state != TX_IDLE);

    // Bit boundary detection and the FIFO pop/push qualification.
    always_comb begin
        bit_end = (div_cnt == '0);
        pop     = !empty && ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));
        push_ok = push && (!full || pop);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Serial frame state machine with registered line output; the bit
    // down-counter reloads from the live divisor at each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            uart_tx <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!empty) begin
                        state   <= TX_START;
                        shift   <= mem[rd_ptr];
                        div_cnt <= divisor;
                        uart_tx <= 1'b0;
                    end else begin
                        uart_tx <= 1'b1;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state   <= TX_DATA;
                        div_cnt <= divisor;
                        bit_cnt <= '0;
                        uart_tx <= shift[0];
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        div_cnt <= divisor;
                        if (bit_cnt == 3'd7) begin
                            state   <= TX_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        div_cnt <= divisor;
                        if (!empty) begin
                            state   <= TX_START;
                            shift   <= mem[rd_ptr];
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= TX_IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/vc_io.sv
// Memory-mapped I/O unit on the core data port. Decodes addr[7:4] = 1..7,
// produces one-cycle rdone/wdone pulses per strobe episode, and hosts the
// UART transmitter, a compare timer and the level interrupt to the core.
// Offsets 0x00-0x0F belong to the QSPI controller and get no response here.
module vc_io
    import vc_io_pkg::*;
#(
    parameter int RV         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 12,
    parameter int TIMER_W    = 16
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            io_access,
    input  logic [1:0]      rstrobe,
    input  logic [RV/8-1:0] wmask,
    input  logic [7:0]      addr,
    input  logic [RV-1:0]   wdata,
    output logic [RV-1:0]   rdata,
    output logic            rdone,
    output logic            wdone,
    output logic            interrupt,
    output logic            uart_tx
);

    localparam int LANES = RV / 8;

    logic                        acked;
    logic [3:0]                  sel;
    logic                        is_read;
    logic                        is_write;
    logic                        mapped;
    logic                        req;
    logic                        tx_stall;
    logic                        done_now;
    logic                        wr_fire;
    logic                        tx_push;
    logic                        timer_hit;
    logic                        tx_idle;

    logic [DIV_W-1:0]            divisor;
    logic [TIMER_W-1:0]          count;
    logic [TIMER_W-1:0]          compare;
    logic [2:0]                  ctrl;
    logic                        pending;

    logic                        tx_full;
    logic                        tx_empty;
    logic                        tx_busy;
    logic [$clog2(FIFO_DEPTH):0] tx_count;

    logic [RV-1:0]               status_word;
    logic [RV-1:0]               read_mux;
    logic                        unused_addr_low;

    // The low nibble of addr is a sub-offset that no register here uses.
    assign unused_addr_low = ^addr[3:0];

    // Merge write data into an old register value, honouring byte lanes.
    function automatic logic [RV-1:0] lane_merge(input logic [RV-1:0]    old_val,
                                                 input logic [RV-1:0]    new_val,
                                                 input logic [LANES-1:0] mask);
        logic [RV-1:0] merged;
        merged = old_val;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Request decode: a TXDATA write into a full FIFO is held off until a slot frees.
    always_comb begin
        sel       = addr[7:4];
        is_read   = |rstrobe;
        is_write  = |wmask;
        mapped    = (sel >= REG_TXDATA) && (sel <= REG_IRQ);
        req       = io_access && (is_read || is_write) && !acked;
        tx_stall  = is_write && (sel == REG_TXDATA) && tx_full;
        done_now  = req && mapped && !tx_stall;
        wr_fire   = done_now && is_write;
        tx_push   = wr_fire && (sel == REG_TXDATA);
        timer_hit = ctrl[CTRL_TIMER_EN] && (count == compare);
        tx_idle   = tx_empty && !tx_busy;
    end

    // Read data selection; narrow registers are zero-extended.
    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY]           = tx_busy;
        status_word[STATUS_FULL]           = tx_full;
        status_word[STATUS_EMPTY]          = tx_empty;
        status_word[STATUS_COUNT_LSB +: 4] = 4'(tx_count);

        read_mux = '0;
        case (sel)
            REG_STATUS:  read_mux = status_word;
            REG_DIVISOR: read_mux = RV'(divisor);
            REG_COUNT:   read_mux = RV'(count);
            REG_COMPARE: read_mux = RV'(compare);
            REG_CTRL:    read_mux = RV'(ctrl);
            REG_IRQ: begin
                read_mux[IRQ_TIMER_PENDING] = pending;
                read_mux[IRQ_TX_IDLE]       = tx_idle;
            end
            default:     read_mux = '0;
        endcase
    end

    // Handshake: one registered done pulse per strobe episode, write wins over read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acked <= 1'b0;
            rdone <= 1'b0;
            wdone <= 1'b0;
            rdata <= '0;
        end else begin
            rdone <= done_now && !is_write;
            wdone <= wr_fire;
            rdata <= (done_now && !is_write) ? read_mux : '0;
            if (!is_read && !is_write) begin
                acked <= 1'b0;
            end else if (done_now) begin
                acked <= 1'b1;
            end
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor <= '0;
            compare <= '1;
            ctrl    <= '0;
        end else if (wr_fire) begin
            case (sel)
                REG_DIVISOR: divisor <= DIV_W'(lane_merge(RV'(divisor), wdata, wmask));
                REG_COMPARE: compare <= TIMER_W'(lane_merge(RV'(compare), wdata, wmask));
                REG_CTRL:    ctrl    <= 3'(lane_merge(RV'(ctrl), wdata, wmask));
                default:     ;
            endcase
        end
    end

    // Compare timer: software write beats increment/wrap; a new match beats a W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_fire && (sel == REG_COUNT)) begin
                count <= TIMER_W'(lane_merge(RV'(count), wdata, wmask));
            end else if (ctrl[CTRL_TIMER_EN]) begin
                count <= (count == compare) ? '0 : count + TIMER_W'(1);
            end

            if (timer_hit) begin
                pending <= 1'b1;
            end else if (wr_fire && (sel == REG_IRQ) && wmask[0] && wdata[IRQ_TIMER_PENDING]) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered interrupt, one cycle behind its sources.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt <= 1'b0;
        end else begin
            interrupt <= (pending && ctrl[CTRL_TIMER_IRQ_EN]) ||
                         (tx_idle && ctrl[CTRL_TXEMPTY_IRQ_EN]);
        end
    end

    vc_uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) u_uart_tx (
        .clk     (clk),
        .reset   (reset),
        .push    (tx_push),
        .data    (wdata[7:0]),
        .divisor (divisor),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .busy    (tx_busy),
        .uart_tx (uart_tx)
    );

endmodule

// File: tb/tb_vc_io.sv
// Directed, table-driven bench for vc_io: register map, handshake, UART
// framing and FIFO back-pressure, timer interrupt and asynchronous reset.
module tb_vc_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_access;
    logic [1:0]  rstrobe;
    logic [1:0]  wmask;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdone;
    logic        wdone;
    logic        interrupt;
    logic        uart_tx;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_cyc   = 0;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [18];

    vc_io #(
        .RV         (16),
        .FIFO_DEPTH (4),
        .DIV_W      (12),
        .TIMER_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .io_access (io_access),
        .rstrobe   (rstrobe),
        .wmask     (wmask),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdone     (rdone),
        .wdone     (wdone),
        .interrupt (interrupt),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Holds one bus request until a done pulse (or the limit), then releases for a cycle.
    task automatic applyStimulus(input logic [1:0] rs, input logic [1:0] wm, input logic [7:0] a,
                                 input logic [15:0] wd, input int limit,
                                 output logic saw_r, output logic saw_w,
                                 output logic [15:0] rd, output int waits);
        io_access = 1'b1;
        rstrobe   = rs;
        wmask     = wm;
        addr      = a;
        wdata     = wd;
        saw_r     = 1'b0;
        saw_w     = 1'b0;
        rd        = '0;
        waits     = 0;
        while (waits < limit && !(saw_r || saw_w)) begin
            @(negedge clk);
            waits++;
            if (rdone === 1'b1) begin
                saw_r = 1'b1;
                rd    = rdata;
            end
            if (wdone === 1'b1) saw_w = 1'b1;
        end
        done_cyc  = cyc;
        io_access = 1'b0;
        rstrobe   = 2'b00;
        wmask     = 2'b00;
        @(negedge clk);
    endtask

    task automatic reg_write(input string name, input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
        logic r, w;
        logic [15:0] rd;
        int waits;
        applyStimulus(2'b00, m, a, d, 20, r, w, rd, waits);
        checkOutput({name, " wdone"}, {31'b0, w}, 32'd1);
    endtask

    task automatic reg_read(input string name, input logic [7:0] a, input logic [15:0] expected);
        logic r, w;
        logic [15:0] rd;
        int waits;
        applyStimulus(2'b01, 2'b00, a, 16'h0, 20, r, w, rd, waits);
        checkOutput({name, " rdone"}, {31'b0, r}, 32'd1);
        checkOutput(name, {16'b0, rd}, {16'b0, expected});
    endtask

    // Samples one serial byte at mid-bit; ok reports a start bit found and a valid stop bit.
    task automatic rx_byte(input int period, output logic [7:0] b, output logic ok);
        int k;
        k = 0;
        b = '0;
        while (uart_tx !== 1'b0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        ok = (uart_tx === 1'b0);
        repeat (period / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            repeat (period) @(negedge clk);
            b[j] = uart_tx;
        end
        repeat (period) @(negedge clk);
        ok = ok && (uart_tx === 1'b1);
    endtask

    initial begin
        logic        got_r, got_w;
        logic [15:0] got_d;
        int          waits, k, pulses, rise1, rise2, t0, lows;
        logic [3:0]  samples;
        logic        expb;
        logic [7:0]  frame_byte;
        logic [7:0]  tx_bytes [6];
        logic [7:0]  rx_bytes [6];
        logic        rx_ok    [6];
        int          wwaits   [6];
        logic        wseen    [6];

        vecs[0]  = '{1'b0, 8'h20, 16'h0000, 2'b00, 16'h0004};
        vecs[1]  = '{1'b0, 8'h50, 16'h0000, 2'b00, 16'hFFFF};
        vecs[2]  = '{1'b1, 8'h50, 16'hABCD, 2'b01, 16'h0000};
        vecs[3]  = '{1'b0, 8'h50, 16'h0000, 2'b00, 16'hFFCD};
        vecs[4]  = '{1'b1, 8'h30, 16'hFFFF, 2'b11, 16'h0000};
        vecs[5]  = '{1'b0, 8'h30, 16'h0000, 2'b00, 16'h0FFF};
        vecs[6]  = '{1'b1, 8'h30, 16'h1234, 2'b10, 16'h0000};
        vecs[7]  = '{1'b0, 8'h30, 16'h0000, 2'b00, 16'h02FF};
        vecs[8]  = '{1'b1, 8'h40, 16'h5A5A, 2'b11, 16'h0000};
        vecs[9]  = '{1'b0, 8'h40, 16'h0000, 2'b00, 16'h5A5A};
        vecs[10] = '{1'b1, 8'h60, 16'h00FF, 2'b01, 16'h0000};
        vecs[11] = '{1'b0, 8'h60, 16'h0000, 2'b00, 16'h0007};
        vecs[12] = '{1'b1, 8'h60, 16'h0000, 2'b11, 16'h0000};
        vecs[13] = '{1'b0, 8'h60, 16'h0000, 2'b00, 16'h0000};
        vecs[14] = '{1'b0, 8'h70, 16'h0000, 2'b00, 16'h0002};
        vecs[15] = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'h0000};
        vecs[16] = '{1'b1, 8'h20, 16'hFFFF, 2'b11, 16'h0000};
        vecs[17] = '{1'b0, 8'h20, 16'h0000, 2'b00, 16'h0004};

        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h3C;
        tx_bytes[3] = 8'hA5; tx_bytes[4] = 8'h0F; tx_bytes[5] = 8'hF0;

        io_access = 1'b0;
        rstrobe   = 2'b00;
        wmask     = 2'b00;
        addr      = 8'h00;
        wdata     = 16'h0000;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Quiet after reset
        repeat (20) @(negedge clk);
        checkOutput("idle uart_tx", {31'b0, uart_tx}, 32'd1);
        checkOutput("idle interrupt", {31'b0, interrupt}, 32'd0);
        checkOutput("idle rdone", {31'b0, rdone}, 32'd0);
        checkOutput("idle wdone", {31'b0, wdone}, 32'd0);

        // Register map table
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                applyStimulus(2'b00, vecs[i].wmask, vecs[i].addr, vecs[i].wdata, 20, got_r, got_w, got_d, waits);
                checkOutput($sformatf("vec%0d wdone", i), {31'b0, got_w}, 32'd1);
            end else begin
                applyStimulus(2'b01, 2'b00, vecs[i].addr, 16'h0, 20, got_r, got_w, got_d, waits);
                checkOutput($sformatf("vec%0d rdone", i), {31'b0, got_r}, 32'd1);
                checkOutput($sformatf("vec%0d rdata", i), {16'b0, got_d}, {16'b0, vecs[i].exp});
            end
        end

        // Read and write together: only the write completes
        applyStimulus(2'b01, 2'b11, 8'h30, 16'h0003, 20, got_r, got_w, got_d, waits);
        checkOutput("rw together wdone", {31'b0, got_w}, 32'd1);
        checkOutput("rw together rdone", {31'b0, got_r}, 32'd0);
        reg_read("divisor=3", 8'h30, 16'h0003);

        // Single 8N1 frame at 4 clocks per bit
        frame_byte = 8'h55;
        applyStimulus(2'b00, 2'b01, 8'h10, {8'h00, frame_byte}, 20, got_r, got_w, got_d, waits);
        checkOutput("txdata wdone", {31'b0, got_w}, 32'd1);
        checkOutput("txdata wdone latency", waits, 32'd1);
        k = 0;
        while (uart_tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      expb = 1'b0;
            else if (b == 9) expb = 1'b1;
            else             expb = frame_byte[b-1];
            for (int s = 0; s < 4; s++) begin
                samples[s] = uart_tx;
                @(negedge clk);
            end
            checkOutput($sformatf("frame bit%0d", b), {28'b0, samples}, {28'b0, {4{expb}}});
        end
        reg_read("status after frame", 8'h20, 16'h0004);

        // FIFO back-pressure at 16 clocks per bit
        reg_write("divisor=15", 8'h30, 16'h000F, 2'b11);
        fork
            begin
                logic        rr;
                logic [15:0] rdd;
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(2'b00, 2'b01, 8'h10, {8'h00, tx_bytes[i]}, 400, rr, wseen[i], rdd, wwaits[i]);
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    rx_byte(16, rx_bytes[j], rx_ok[j]);
                end
            end
        join
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("burst write%0d latency", i), wwaits[i], 32'd1);
        end
        checkOutput("6th write stalled then done", {31'b0, (wseen[5] && wwaits[5] > 100)}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("rx byte%0d", i), {24'b0, rx_bytes[i]}, {24'b0, tx_bytes[i]});
            checkOutput($sformatf("rx framing%0d", i), {31'b0, rx_ok[i]}, 32'd1);
        end

        // Compare timer and interrupt
        reg_write("count=0", 8'h40, 16'h0000, 2'b11);
        reg_write("compare=9", 8'h50, 16'h0009, 2'b11);
        checkOutput("irq low before enable", {31'b0, interrupt}, 32'd0);
        applyStimulus(2'b00, 2'b01, 8'h60, 16'h0003, 20, got_r, got_w, got_d, waits);
        t0 = done_cyc;
        k = 0;
        while (interrupt !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        rise1 = cyc;
        checkOutput("irq rise latency", rise1 - t0, 32'd11);
        reg_write("irq clear", 8'h70, 16'h0001, 2'b01);
        checkOutput("irq after clear", {31'b0, interrupt}, 32'd0);
        k = 0;
        while (interrupt !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        rise2 = cyc;
        checkOutput("irq period", rise2 - rise1, 32'd10);
        reg_write("ctrl=0", 8'h60, 16'h0000, 2'b11);
        reg_write("irq clear2", 8'h70, 16'h0001, 2'b01);
        checkOutput("irq off", {31'b0, interrupt}, 32'd0);

        // Held read strobe gives exactly one rdone
        io_access = 1'b1; rstrobe = 2'b01; addr = 8'h40; pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdone === 1'b1) pulses++;
        end
        io_access = 1'b0; rstrobe = 2'b00;
        @(negedge clk);
        checkOutput("held read pulses", pulses, 32'd1);

        // Unmapped offset (QSPI range) gives no response
        io_access = 1'b1; rstrobe = 2'b01; wmask = 2'b01; addr = 8'h00; pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdone === 1'b1 || wdone === 1'b1) pulses++;
        end
        io_access = 1'b0; rstrobe = 2'b00; wmask = 2'b00;
        @(negedge clk);
        checkOutput("unmapped pulses", pulses, 32'd0);

        // Asynchronous reset in the middle of a data bit
        reg_write("txdata 0x00", 8'h10, 16'h0000, 2'b01);
        k = 0;
        while (uart_tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        checkOutput("mid-data line low", {31'b0, uart_tx}, 32'd0);
        #2 reset = 1'b1;
        #1 checkOutput("async reset uart_tx", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reg_read("status after reset", 8'h20, 16'h0004);
        reg_read("divisor after reset", 8'h30, 16'h0000);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checkOutput("no serial after reset", lows, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
